// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage: widths, special registers
// and the writeback-select encoding.
package mem_wb_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_RA_REG = 31;
  localparam int WB_CNT_W  = 32;
  localparam int ZERO_REG  = 0;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // A link instruction always writes PC+4, whatever memToReg says.
  function automatic wb_sel_e wb_sel_of(input logic is_jal, input logic mem_to_reg);
    if (is_jal)     return WB_LINK;
    if (mem_to_reg) return WB_MEM;
    return WB_ALU;
  endfunction

endpackage

// File: rtl/mem_wb_stage_wb_select_mux.sv
// Writeback data mux: picks ALU result, load data or link address.
module wb_select_mux
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  wb_sel_e             sel_i,
  input  logic [DATA_W-1:0]   alu_i,
  input  logic [DATA_W-1:0]   mem_i,
  input  logic [DATA_W-1:0]   link_i,
  output logic [DATA_W-1:0]   data_o
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of latches.
    data_o = alu_i;
    case (sel_i)
      WB_MEM:  data_o = mem_i;
      WB_LINK: data_o = link_i;
      default: data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and register-file writeback driver with stall,
// flush, $0 write suppression and a retired-instruction counter.
// Optional same-cycle read bypass ports are added when WB_BYPASS_EN is defined.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int RA_REG = WB_RA_REG,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic              memToReg,
  input  logic              memIsJal,
  input  logic [ADDR_W-1:0] memDst,
  input  logic [DATA_W-1:0] memAluRes,
  input  logic [DATA_W-1:0] memLoadData,
  input  logic [DATA_W-1:0] memPcPlus4,
  output logic [ADDR_W-1:0] adrW,
  output logic              writeEn,
  output logic [DATA_W-1:0] inW,
  output logic              wbValid,
  output logic [CNT_W-1:0]  retired
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rdAdrA,
  input  logic [ADDR_W-1:0] rdAdrB,
  input  logic [DATA_W-1:0] rfOutA,
  input  logic [DATA_W-1:0] rfOutB,
  output logic [DATA_W-1:0] fwdA,
  output logic [DATA_W-1:0] fwdB
`endif
);

  logic              valid_q,     valid_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] dst_q,       dst_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [CNT_W-1:0]  retired_q,   retired_d;
  logic [DATA_W-1:0] cap_data;

  wb_select_mux #(
    .DATA_W (DATA_W)
  ) u_wb_select_mux (
    .sel_i  (wb_sel_of(memIsJal, memToReg)),
    .alu_i  (memAluRes),
    .mem_i  (memLoadData),
    .link_i (memPcPlus4),
    .data_o (cap_data)
  );

  // Flush beats stall; on flush the data registers simply hold.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    dst_d       = dst_q;
    data_d      = data_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = memValid;
      reg_write_d = memValid & memRegWrite;
      dst_d       = memIsJal ? ADDR_W'(RA_REG) : memDst;
      data_d      = cap_data;
    end
  end

  // An instruction retires when it leaves WB, i.e. a valid slot that is not held.
  always_comb begin
    retired_d = retired_q;
    if (valid_q && !stall) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      dst_q       <= '0;
      data_q      <= '0;
      retired_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      retired_q   <= retired_d;
    end
  end

  assign adrW    = dst_q;
  assign inW     = data_q;
  assign wbValid = valid_q;
  assign retired = retired_q;
  assign writeEn = reg_write_q & valid_q & (dst_q != ADDR_W'(ZERO_REG));

`ifdef WB_BYPASS_EN
  assign fwdA = (writeEn && (rdAdrA == adrW)) ? inW : rfOutA;
  assign fwdB = (writeEn && (rdAdrB == adrW)) ? inW : rfOutB;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: reset, directed vector table,
// hand-written stall/reset sequences and randomized run against a model.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, memValid, memRegWrite, memToReg, memIsJal;
  logic [4:0]  memDst;
  logic [31:0] memAluRes, memLoadData, memPcPlus4;
  logic [4:0]  adrW, adrW3;
  logic        writeEn, wbValid, writeEn3, wbValid3;
  logic [31:0] inW, inW3;
  logic [31:0] retired;
  logic [2:0]  retired3;
`ifdef WB_BYPASS_EN
  logic [4:0]  rdAdrA, rdAdrB;
  logic [31:0] rfOutA, rfOutB, fwdA, fwdB, fwdA3, fwdB3;
`endif

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .memValid(memValid), .memRegWrite(memRegWrite), .memToReg(memToReg),
    .memIsJal(memIsJal), .memDst(memDst), .memAluRes(memAluRes),
    .memLoadData(memLoadData), .memPcPlus4(memPcPlus4),
    .adrW(adrW), .writeEn(writeEn), .inW(inW), .wbValid(wbValid),
    .retired(retired)
`ifdef WB_BYPASS_EN
    , .rdAdrA(rdAdrA), .rdAdrB(rdAdrB), .rfOutA(rfOutA), .rfOutB(rfOutB),
    .fwdA(fwdA), .fwdB(fwdB)
`endif
  );

  // Narrow counter instance so wrap-around is reachable.
  mem_wb_stage #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .memValid(memValid), .memRegWrite(memRegWrite), .memToReg(memToReg),
    .memIsJal(memIsJal), .memDst(memDst), .memAluRes(memAluRes),
    .memLoadData(memLoadData), .memPcPlus4(memPcPlus4),
    .adrW(adrW3), .writeEn(writeEn3), .inW(inW3), .wbValid(wbValid3),
    .retired(retired3)
`ifdef WB_BYPASS_EN
    , .rdAdrA(rdAdrA), .rdAdrB(rdAdrB), .rfOutA(rfOutA), .rfOutB(rfOutB),
    .fwdA(fwdA3), .fwdB(fwdB3)
`endif
  );

  // Register file committing on the negedge, as the core does.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (writeEn === 1'b1) rf[adrW] <= inW;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic tr, input logic j,
                         input logic [4:0] d, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4);
    memValid = v; memRegWrite = rw; memToReg = tr; memIsJal = j;
    memDst = d; memAluRes = alu; memLoadData = ld; memPcPlus4 = pc4;
  endtask

  typedef struct {
    logic        stall, flush, valid, regw, toreg, jal;
    logic [4:0]  dst;
    logic [31:0] alu, ld, pc4;
    logic [4:0]  e_adr;
    logic        e_we;
    logic [31:0] e_data;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_ret;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic v, input logic rw,
                              input logic tr, input logic j, input logic [4:0] d,
                              input logic [31:0] alu, input logic [31:0] ld,
                              input logic [31:0] pc4, input logic [4:0] ea,
                              input logic ewe, input logic [31:0] ed, input logic cd,
                              input logic ev, input logic [31:0] er);
    vec_t r;
    r.stall = s; r.flush = f; r.valid = v; r.regw = rw; r.toreg = tr; r.jal = j;
    r.dst = d; r.alu = alu; r.ld = ld; r.pc4 = pc4;
    r.e_adr = ea; r.e_we = ewe; r.e_data = ed; r.chk_data = cd; r.e_valid = ev; r.e_ret = er;
    return r;
  endfunction

  vec_t vecs[15];

  // Behavioural model state for the random run.
  logic        m_valid, m_rw, m_known;
  logic [4:0]  m_dst;
  logic [31:0] m_data, m_ret;

  initial begin
    //            s  f  v  rw tr j  dst alu           ld         pc4    e_adr we data          cd v  ret
    vecs[0]  = mk(0, 0, 1, 1, 0, 0, 8,  32'h0000_00AA, 32'h0,     32'h0, 8,   1, 32'h0000_00AA, 1, 1, 0);
    vecs[1]  = mk(0, 0, 1, 1, 1, 0, 3,  32'h5,         32'h1234,  32'h0, 3,   1, 32'h1234,      1, 1, 1);
    vecs[2]  = mk(0, 0, 1, 1, 1, 1, 5,  32'h6,         32'h7,     32'h40, 31, 1, 32'h40,        1, 1, 2);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0, 0,  32'hFFFF_FFFF, 32'h0,     32'h0, 0,   0, 32'hFFFF_FFFF, 1, 1, 3);
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 7,  32'h11,        32'h0,     32'h0, 7,   0, 32'h11,        1, 1, 4);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 9,  32'h22,        32'h0,     32'h0, 9,   0, 32'h22,        1, 0, 5);
    vecs[6]  = mk(1, 0, 1, 1, 0, 0, 12, 32'h33,        32'h0,     32'h0, 9,   0, 32'h22,        1, 0, 5);
    vecs[7]  = mk(0, 0, 1, 1, 0, 0, 12, 32'h33,        32'h0,     32'h0, 12,  1, 32'h33,        1, 1, 5);
    vecs[8]  = mk(1, 0, 1, 1, 0, 0, 13, 32'h44,        32'h0,     32'h0, 12,  1, 32'h33,        1, 1, 5);
    vecs[9]  = mk(1, 0, 1, 1, 1, 0, 13, 32'h44,        32'h45,    32'h0, 12,  1, 32'h33,        1, 1, 5);
    vecs[10] = mk(1, 0, 1, 1, 0, 1, 13, 32'h44,        32'h0,     32'h46, 12, 1, 32'h33,        1, 1, 5);
    vecs[11] = mk(1, 1, 1, 1, 0, 0, 14, 32'h47,        32'h0,     32'h0, 0,   0, 32'h0,         0, 0, 5);
    vecs[12] = mk(0, 0, 1, 1, 0, 0, 4,  32'h55,        32'h0,     32'h0, 4,   1, 32'h55,        1, 1, 5);
    vecs[13] = mk(0, 1, 1, 1, 0, 0, 6,  32'h56,        32'h0,     32'h0, 0,   0, 32'h0,         0, 0, 6);
    vecs[14] = mk(0, 0, 0, 1, 0, 0, 2,  32'h66,        32'h0,     32'h0, 2,   0, 32'h66,        1, 0, 6);

    for (int i = 0; i < 32; i++) rf[i] = '0;
    stall = 0; flush = 0;
`ifdef WB_BYPASS_EN
    rdAdrA = 0; rdAdrB = 0; rfOutA = 0; rfOutB = 0;
`endif

    // Reset held two cycles with a real writing instruction on the inputs.
    rst = 1;
    set_mem(1, 1, 0, 0, 5'd8, 32'hDEAD, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset_we", writeEn, 0);
      check("reset_valid", wbValid, 0);
      check("reset_retired", retired, 0);
      check("reset_adr", adrW, 0);
      check("reset_data", inW, 0);
    end
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush;
      set_mem(vecs[i].valid, vecs[i].regw, vecs[i].toreg, vecs[i].jal,
              vecs[i].dst, vecs[i].alu, vecs[i].ld, vecs[i].pc4);
      step();
      check($sformatf("v%0d_we", i), writeEn, vecs[i].e_we);
      check($sformatf("v%0d_valid", i), wbValid, vecs[i].e_valid);
      check($sformatf("v%0d_retired", i), retired, vecs[i].e_ret);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_adr", i), adrW, vecs[i].e_adr);
        check($sformatf("v%0d_data", i), inW, vecs[i].e_data);
      end
    end
    stall = 0; flush = 0;

    @(negedge clk); #1;
    check("rf8", rf[8], 32'h0000_00AA);
    check("rf3", rf[3], 32'h1234);
    check("rf31", rf[31], 32'h40);
    check("rf12", rf[12], 32'h33);
    check("rf0", rf[0], 32'h0);

`ifdef WB_BYPASS_EN
    set_mem(1, 1, 0, 0, 5'd9, 32'h77, 32'h0, 32'h0);
    step();
    rdAdrA = 9; rdAdrB = 10; rfOutA = 32'h123; rfOutB = 32'h456;
    #1;
    check("fwdA_hit", fwdA, 32'h77);
    check("fwdB_miss", fwdB, 32'h456);
    set_mem(1, 1, 0, 0, 5'd0, 32'h88, 32'h0, 32'h0);
    step();
    rdAdrA = 0; rfOutA = 32'h0;
    #1;
    check("fwdA_zero", fwdA, 32'h0);
`endif

    // Reset arriving during a stall drops the held instruction.
    rst = 1; step(); rst = 0;
    set_mem(1, 1, 0, 0, 5'd6, 32'h99, 32'h0, 32'h0);
    step();
    check("ms_we_before", writeEn, 1);
    stall = 1; rst = 1;
    step();
    check("ms_we", writeEn, 0);
    check("ms_valid", wbValid, 0);
    check("ms_retired", retired, 0);
    rst = 0;
    step();
    check("ms_after_we", writeEn, 0);
    check("ms_after_retired", retired, 0);
    stall = 0;

    // Randomized run against the model; start from a known reset.
    rst = 1; step(); rst = 0;
    m_valid = 0; m_rw = 0; m_dst = 0; m_data = 0; m_known = 1; m_ret = 0;
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0, 5'($urandom_range(0, 31)), $urandom(), $urandom(),
              $urandom());
      step();
      if (rst) begin
        m_valid = 0; m_rw = 0; m_dst = 0; m_data = 0; m_known = 1; m_ret = 0;
      end else begin
        if (m_valid && !stall) m_ret = m_ret + 1;
        if (flush) begin
          m_valid = 0; m_rw = 0; m_known = 0;
        end else if (!stall) begin
          m_valid = memValid;
          m_rw    = memValid && memRegWrite;
          m_dst   = memIsJal ? 5'd31 : memDst;
          m_data  = memIsJal ? memPcPlus4 : (memToReg ? memLoadData : memAluRes);
          m_known = 1;
        end
      end
      check("rnd_valid", wbValid, m_valid);
      check("rnd_we", writeEn, m_rw && m_valid && (m_dst != 0));
      check("rnd_retired", retired, m_ret);
      check("rnd_retired_wrap", retired3, m_ret % 8);
      if (m_known) begin
        check("rnd_adr", adrW, m_dst);
        check("rnd_data", inW, m_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
